sipo_frame: RTL and testbench
=============================

Name: sipo_frame

Overview:
- Serial-in, parallel-out frame assembler. It consumes the Q bit stream of the rdtype D flip-flop stage directly upstream.
- Shifts in one bit per enabled clock and publishes each completed WIDTH-bit word on a held parallel register with a one-cycle Valid strobe.
- Provides the word-level interface for the downstream datapath in the desex3 flow.

Parameters:
WIDTH, 8, bits per frame; legal range 2..16.

Ports:
Clk     input   1      system clock; all state updates on rising edge
nRst    input   1      asynchronous active-low reset
SerIn   input   1      serial data bit, driven from upstream rdtype Q
Enable  input   1      sample SerIn on this rising edge when high
Clear   input   1      synchronous frame abort; discards partial frame
Data    output  WIDTH  last completed frame, MSB = first bit received
Valid   output  1      one-cycle strobe: Data updated on the preceding edge
Busy    output  1      high while a partial frame is held (bit count != 0)

Behaviour:
- Reset (nRst low, asynchronous): shift register = 0, bit count = 0, state = IDLE, Data = 0, Valid = 0, Busy = 0. All outputs are registered, so this holds during reset.
- States (enum): IDLE (count 0), SHIFT (0 < count < WIDTH), PARITY (feature only).
- Edge with Enable=1, Clear=0: shreg <= {shreg[WIDTH-2:0], SerIn}; count <= count+1; IDLE->SHIFT.
- Edge with Enable=0: all state holds. A stall mid-frame loses no bits. Valid is forced 0.
- Completing edge (count == WIDTH-1 and Enable=1):
  - Data <= {shreg[WIDTH-2:0], SerIn}.
  - Valid = 1 for the following cycle only.
  - count <= 0; state -> IDLE.
- Latency: Valid and the new Data are visible immediately after the edge that samples the last bit.
- Back-to-back frames: with Enable held high, Valid pulses once every WIDTH cycles with no gap cycle.
- Data is held between frames. It changes only on a completing edge or on reset.
- Busy = (count != 0), registered.
- Clear=1: count <= 0, state <= IDLE, shreg <= 0, Valid <= 0. Data is unchanged.
  - Clear has priority over Enable on the same edge, including a completing edge: that frame is dropped and no Valid is produced.
- Reset asserted mid-frame: immediate return to reset values. The partial frame is lost and no Valid is produced.
- Counter width: $clog2(WIDTH+1) bits. It never exceeds WIDTH and wraps only via the explicit return to 0.

Optional Feature:
Macro SIPO_PARITY_EN.
- Defined:
  - After WIDTH data bits the FSM enters PARITY. The next enabled bit is an even-parity bit and is not shifted into Data.
  - On that edge: Data <= the WIDTH data bits; Valid pulses; output ParErr (1 bit, registered) <= XOR(data bits, parity bit).
  - ParErr holds until the next Valid. Reset and Clear both drive ParErr to 0.
  - Frame period becomes WIDTH+1 enabled cycles. Clear in PARITY aborts the frame with no Valid.
- Undefined:
  - No PARITY state and no ParErr port. Behaviour is exactly as above.

Decomposition:
- Package sipo_pkg: state enum sipo_state_t {IDLE, SHIFT, PARITY}; localparam DEFAULT_WIDTH = 8.
- One sub-module: sipo_bitcnt.
  - Ports: Clk, nRst, clr, inc, count, last.
  - Parameterised modulus, giving WIDTH or WIDTH+1 under the macro.
- Top level holds the FSM, shift register and output registers.

Test Plan:
- Reset: nRst=0 for 100 ns with SerIn toggling -> Data=8'h00, Valid=0, Busy=0 throughout.
- Single frame: Enable=1, SerIn = 1,0,1,1,0,0,1,0 on consecutive edges -> after the 8th edge Data=8'hB2, Valid high exactly one cycle, Busy 1 on edges 1-7 then 0.
- Stall: send 4 bits of 8'hA5, drop Enable for 5 cycles, send the remaining 4 -> Data=8'hA5, one Valid only after the 8th enabled edge.
- Back-to-back and abort:
  - Continuous frames 8'h3C then 8'hFF -> Valid pulses exactly 8 cycles apart, Data=8'h3C then 8'hFF.
  - Clear asserted with the 8th bit of 8'h55 -> no Valid, Data keeps 8'hFF, Busy=0.
- Mid-frame reset: nRst low after 5 bits, then a full frame 8'h81 -> only one Valid, Data=8'h81.
- SIPO_PARITY_EN:
  - 8'h0F then parity 0 -> Valid, ParErr=0.
  - 8'h0E then parity 0 -> Valid, ParErr=1.
  - Valid period is 9 cycles.

Source files
------------

// File: rtl/sipo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sipo_pkg
// Purpose  : Shared types and constants for the sipo_frame assembler.
//            - sipo_state_t : frame FSM state encoding
//            - DEFAULT_WIDTH: default bits per frame
//            - cnt_bits()   : counter width needed to hold 0..modulus
// Revision : 1.0 - initial release
// ============================================================================
package sipo_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,   // no bits of the current frame held
      SHIFT  = 2'd1,   // partial frame held
      PARITY = 2'd2    // all data bits held, waiting for the parity bit
   } sipo_state_t;

   localparam int DEFAULT_WIDTH = 8;

   function automatic int cnt_bits(input int modulus);
      return $clog2(modulus + 1);
   endfunction

endpackage : sipo_pkg
`default_nettype wire

// File: rtl/sipo_bitcnt.sv
`default_nettype none
// ============================================================================
// Module   : sipo_bitcnt
// Purpose  : Bit-position counter for the frame assembler. Counts enabled
//            bits from 0 up to MODULUS-1 and returns to 0 on the bit after
//            that. A synchronous clear forces 0 and wins over inc.
// Ports    : Clk   - clock, rising edge
//            nRst  - asynchronous active-low reset
//            clr   - synchronous clear to 0
//            inc   - advance the count on this edge
//            count - current count (0..MODULUS-1)
//            last  - count is at MODULUS-1 (next inc wraps to 0)
// Revision : 1.0 - initial release
// ============================================================================
module sipo_bitcnt
   import sipo_pkg::*;
#(
   parameter int MODULUS = DEFAULT_WIDTH,
   parameter int CNT_W   = cnt_bits(MODULUS)
) (
   input  logic             Clk,
   input  logic             nRst,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count,
   output logic             last
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   assign last  = (count_q == CNT_W'(MODULUS - 1));
   assign count = count_q;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc) begin
         count_d = last ? '0 : count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge Clk or negedge nRst) begin
      if (!nRst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule : sipo_bitcnt
`default_nettype wire

// File: rtl/sipo_frame.sv
`default_nettype none
// ============================================================================
// Module   : sipo_frame
// Purpose  : Serial-in, parallel-out frame assembler. Shifts one bit per
//            enabled clock (first bit lands in the MSB) and publishes each
//            completed WIDTH-bit word on a held Data register together with
//            a one-cycle Valid strobe.
// Build    : define SIPO_PARITY_EN to append an even-parity bit to every
//            frame; the result of the check appears on ParErr.
// Ports    : Clk    - clock, rising edge
//            nRst   - asynchronous active-low reset
//            SerIn  - serial data bit
//            Enable - sample SerIn on this edge
//            Clear  - synchronous frame abort (priority over Enable)
//            Data   - last completed frame, MSB = first bit received
//            Valid  - one-cycle strobe, Data updated on the preceding edge
//            Busy   - a partial frame is held
//            ParErr - (SIPO_PARITY_EN only) parity check of the last frame
// Revision : 1.0 - initial release
// ============================================================================
module sipo_frame
   import sipo_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             Clk,
   input  logic             nRst,
   input  logic             SerIn,
   input  logic             Enable,
   input  logic             Clear,
   output logic [WIDTH-1:0] Data,
   output logic             Valid,
   output logic             Busy
`ifdef SIPO_PARITY_EN
   ,
   output logic             ParErr
`endif
);

`ifdef SIPO_PARITY_EN
   localparam int FRAME_LEN = WIDTH + 1;
`else
   localparam int FRAME_LEN = WIDTH;
`endif
   localparam int CNT_W = cnt_bits(FRAME_LEN);

   sipo_state_t      state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [WIDTH-1:0] data_q,  data_d;
   logic             valid_q, valid_d;
   logic             busy_q,  busy_d;
`ifdef SIPO_PARITY_EN
   logic             parerr_q, parerr_d;
`endif

   logic [CNT_W-1:0] cnt_count;
   logic             cnt_last;

   // The counter tracks the bit position of the whole frame (including the
   // parity bit when that is built in); the FSM only steers data flow.
   sipo_bitcnt #(
      .MODULUS (FRAME_LEN),
      .CNT_W   (CNT_W)
   ) u_bitcnt (
      .Clk   (Clk),
      .nRst  (nRst),
      .clr   (Clear),
      .inc   (Enable & ~Clear),
      .count (cnt_count),
      .last  (cnt_last)
   );

   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      data_d   = data_q;
      valid_d  = 1'b0;
      busy_d   = (cnt_count != '0);
`ifdef SIPO_PARITY_EN
      parerr_d = parerr_q;
`endif

      if (Clear) begin
         // Abort wins even over a completing edge: the frame is dropped.
         state_d  = IDLE;
         shreg_d  = '0;
         busy_d   = 1'b0;
`ifdef SIPO_PARITY_EN
         parerr_d = 1'b0;
`endif
      end else if (Enable) begin
         // After this edge the count is either advanced (non-zero) or has
         // wrapped on the final bit of the frame.
         busy_d = ~cnt_last;
         case (state_q)
            IDLE, SHIFT: begin
               shreg_d = {shreg_q[WIDTH-2:0], SerIn};
`ifdef SIPO_PARITY_EN
               // Last data bit moves to PARITY; the word is published only
               // once the parity bit arrives.
               state_d = (cnt_count == CNT_W'(WIDTH - 1)) ? PARITY : SHIFT;
`else
               if (cnt_last) begin
                  data_d  = shreg_d;
                  valid_d = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = SHIFT;
               end
`endif
            end
`ifdef SIPO_PARITY_EN
            PARITY: begin
               // Parity bit is checked but never shifted into the word.
               data_d   = shreg_q;
               valid_d  = 1'b1;
               parerr_d = (^shreg_q) ^ SerIn;
               state_d  = IDLE;
            end
`endif
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge Clk or negedge nRst) begin
      if (!nRst) begin
         state_q  <= IDLE;
         shreg_q  <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
`ifdef SIPO_PARITY_EN
         parerr_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         shreg_q  <= shreg_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
`ifdef SIPO_PARITY_EN
         parerr_q <= parerr_d;
`endif
      end
   end

   assign Data  = data_q;
   assign Valid = valid_q;
   assign Busy  = busy_q;
`ifdef SIPO_PARITY_EN
   assign ParErr = parerr_q;
`endif

endmodule : sipo_frame
`default_nettype wire

// File: tb/tb_sipo_frame.sv
`default_nettype none
// ============================================================================
// Module   : tb_sipo_frame
// Purpose  : Self-checking bench for sipo_frame. A driver issues directed
//            and random bit streams and feeds a bit-queue reference model
//            that pushes each expected frame into a scoreboard; a monitor
//            on the falling edge compares Valid/Data/Busy (and ParErr).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sipo_frame;

   localparam int WIDTH = 8;
`ifdef SIPO_PARITY_EN
   localparam int FLEN = WIDTH + 1;
`else
   localparam int FLEN = WIDTH;
`endif

   logic             Clk    = 1'b0;
   logic             nRst   = 1'b0;
   logic             SerIn  = 1'b0;
   logic             Enable = 1'b0;
   logic             Clear  = 1'b0;
   logic [WIDTH-1:0] Data;
   logic             Valid;
   logic             Busy;
`ifdef SIPO_PARITY_EN
   logic             ParErr;
`endif

   sipo_frame #(.WIDTH(WIDTH)) dut (
      .Clk    (Clk),
      .nRst   (nRst),
      .SerIn  (SerIn),
      .Enable (Enable),
      .Clear  (Clear),
      .Data   (Data),
      .Valid  (Valid),
      .Busy   (Busy)
`ifdef SIPO_PARITY_EN
      ,
      .ParErr (ParErr)
`endif
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [WIDTH-1:0] d;
      logic             p;
   } exp_t;

   exp_t             exp_q[$];
   bit               frame_bits[$];
   logic             exp_busy  = 1'b0;
   logic             exp_valid = 1'b0;
   logic [WIDTH-1:0] held_data = '0;
   logic             held_par  = 1'b0;
   exp_t             mon_e;
   int               errors = 0;
   int               checks = 0;

   function automatic void chk(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Reference model: collect bits of the current frame; when a full frame
   // is present, the first WIDTH bits form the word (MSB first) and the
   // parity flag is the XOR of every bit received for the frame.
   task automatic model_edge();
      exp_t e;
      exp_valid = 1'b0;
      if (Clear) begin
         frame_bits.delete();
      end else if (Enable) begin
         frame_bits.push_back(SerIn);
         if (frame_bits.size() == FLEN) begin
            e.d = '0;
            e.p = 1'b0;
            for (int i = 0; i < WIDTH; i++) e.d = {e.d[WIDTH-2:0], frame_bits[i]};
            for (int i = 0; i < FLEN; i++)  e.p = e.p ^ frame_bits[i];
            exp_q.push_back(e);
            exp_valid = 1'b1;
            frame_bits.delete();
         end
      end
      exp_busy = (frame_bits.size() != 0);
   endtask

   task automatic cyc(input logic en, input logic b, input logic clr);
      @(negedge Clk);
      Enable = en;
      SerIn  = b;
      Clear  = clr;
      @(posedge Clk);
      model_edge();
   endtask

   task automatic send_word(input logic [WIDTH-1:0] w, input int nbits);
      for (int i = 0; i < nbits; i++) cyc(1'b1, w[WIDTH-1-i], 1'b0);
   endtask

   task automatic reset_pulse();
      @(negedge Clk);
      #2 nRst = 1'b0;
      frame_bits.delete();
      exp_q.delete();
      exp_busy  = 1'b0;
      exp_valid = 1'b0;
      Enable    = 1'b1;
      Clear     = 1'b0;
      repeat (10) begin
         @(negedge Clk);
         #1 SerIn = ~SerIn;
      end
      @(negedge Clk);
      #2 nRst = 1'b1;
      Enable = 1'b0;
   endtask

   always @(negedge Clk) begin
      if (!nRst) begin
         chk("reset_data", 32'(Data), 32'h0);
         chk("reset_valid", 32'(Valid), 32'h0);
         chk("reset_busy", 32'(Busy), 32'h0);
         held_data = '0;
         held_par  = 1'b0;
      end else begin
         chk("valid", 32'(Valid), 32'(exp_valid));
         chk("busy", 32'(Busy), 32'(exp_busy));
         if (Valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_valid: got Valid=1 expected no frame at %0t", $time);
            end else begin
               mon_e     = exp_q.pop_front();
               held_data = mon_e.d;
               held_par  = mon_e.p;
            end
         end
         chk("data", 32'(Data), 32'(held_data));
`ifdef SIPO_PARITY_EN
         chk("parerr", 32'(ParErr), 32'(held_par));
`endif
      end
   end

   initial begin
      // Power-on reset with SerIn toggling for 100 ns.
      Enable = 1'b1;
      repeat (10) begin
         @(negedge Clk);
         #1 SerIn = ~SerIn;
      end
      @(negedge Clk);
      #2 nRst = 1'b1;
      Enable = 1'b0;

      cyc(1'b0, 1'b0, 1'b0);
      send_word(8'hB2, 8);
      cyc(1'b0, 1'b0, 1'b0);
`ifdef SIPO_PARITY_EN
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
`endif

      // Stall mid-frame.
      send_word(8'hA5, 4);
      repeat (5) cyc(1'b0, 1'b1, 1'b0);
      send_word(8'h5A, 4);            // low nibble of A5 == high nibble of 5A
`ifdef SIPO_PARITY_EN
      cyc(1'b1, 1'b1, 1'b0);
`endif
      cyc(1'b0, 1'b0, 1'b0);

      // Back-to-back frames, then abort on the final bit.
      send_word(8'h3C, 8);
`ifdef SIPO_PARITY_EN
      cyc(1'b1, 1'b0, 1'b0);
`endif
      send_word(8'hFF, 8);
`ifdef SIPO_PARITY_EN
      cyc(1'b1, 1'b0, 1'b0);
`endif
      send_word(8'h55, FLEN - 1);
      cyc(1'b1, 1'b1, 1'b1);
      cyc(1'b0, 1'b0, 1'b0);

      // Reset mid-frame, then a clean frame.
      send_word(8'hE7, 5);
      reset_pulse();
      send_word(8'h81, 8);
`ifdef SIPO_PARITY_EN
      cyc(1'b1, 1'b0, 1'b0);
      send_word(8'h0F, 8);
      cyc(1'b1, 1'b0, 1'b0);
      send_word(8'h0E, 8);
      cyc(1'b1, 1'b0, 1'b0);
`endif
      cyc(1'b0, 1'b0, 1'b0);

      // Random traffic.
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 199) == 0) begin
            reset_pulse();
         end else begin
            cyc(1'($urandom_range(0, 3) != 0), 1'($urandom),
                1'($urandom_range(0, 24) == 0));
         end
      end
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);

      chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_sipo_frame
`default_nettype wire
